// File: rtl/ps2_sync.sv
// Three-flop synchroniser for one asynchronous PS/2 line, with falling-edge detect.
// Stand-alone so the keyboard receiver can instantiate the same block.
module ps2_sync (
    input  logic i_clk,
    input  logic i_clrn,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic [2:0] r_sync;

    // Idle PS/2 lines float high, so the flops reset to 1 to avoid a false edge.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], i_line};
        end
    end

    assign o_level = r_sync[1];
    assign o_fall  = r_sync[2] & ~r_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10 clocked bits,
// then the device ACK bit, with a shared inhibit/watchdog timer.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    // Start + 8 data + parity + stop; the host drives bits after start on falling edges.
    localparam int         FRAME_BITS = 11;
    localparam logic [3:0] STOP_IDX   = 4'(FRAME_BITS - 2);

    localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic               w_clk_fall;
    logic               w_data_level;
    logic               w_clk_level_unused;
    logic               w_data_fall_unused;

    logic [2:0]         r_state,    w_state;
    logic [9:0]         r_frame,    w_frame;
    logic [3:0]         r_idx,      w_idx;
    logic [TIMER_W-1:0] r_timer,    w_timer;
    logic               r_clk_oe,   w_clk_oe;
    logic               r_data_oe,  w_data_oe;
    logic               r_err,      w_err;

    ps2_sync u_sync_clk (
        .i_clk   (clk),
        .i_clrn  (clrn),
        .i_line  (ps2_clk),
        .o_level (w_clk_level_unused),
        .o_fall  (w_clk_fall)
    );

    ps2_sync u_sync_data (
        .i_clk   (clk),
        .i_clrn  (clrn),
        .i_line  (ps2_data),
        .o_level (w_data_level),
        .o_fall  (w_data_fall_unused)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_idx     <= '0;
            r_timer   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_frame   <= w_frame;
            r_idx     <= w_idx;
            r_timer   <= w_timer;
            r_clk_oe  <= w_clk_oe;
            r_data_oe <= w_data_oe;
            r_err     <= w_err;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_frame   = r_frame;
        w_idx     = r_idx;
        w_timer   = r_timer;
        w_clk_oe  = r_clk_oe;
        w_data_oe = r_data_oe;
        w_err     = r_err;
        case (r_state)
            S_IDLE: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                w_timer   = '0;
                if (valid) begin
                    w_frame  = {1'b1, odd_parity(data_in), data_in};
                    w_err    = 1'b0;
                    w_clk_oe = 1'b1;
                    w_state  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_timer == INHIBIT_LAST) begin
                    w_clk_oe  = 1'b0;
                    w_data_oe = 1'b1;
                    w_idx     = '0;
                    w_timer   = '0;
                    w_state   = S_SEND;
                end else begin
                    w_timer = r_timer + TIMER_W'(1);
                end
            end
            S_SEND, S_ACK: begin
                // The same timer now measures the gap between device clock edges.
                if (w_clk_fall) begin
                    w_timer = '0;
                    if (r_state == S_SEND) begin
                        w_data_oe = ~r_frame[r_idx];
                        w_idx     = r_idx + 4'd1;
                        if (r_idx == STOP_IDX) begin
                            w_state = S_ACK;
                        end
                    end else begin
                        w_err   = w_data_level;
                        w_state = S_FIN;
                    end
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_clk_oe  = 1'b0;
                    w_data_oe = 1'b0;
                    w_err     = 1'b1;
                    w_state   = S_FIN;
                end else begin
                    w_timer = r_timer + TIMER_W'(1);
                end
            end
            S_FIN: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                w_timer   = '0;
                w_state   = S_IDLE;
            end
            default: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                w_timer   = '0;
                w_state   = S_IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign ready       = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FIN);
    assign err         = (r_state == S_FIN) & r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed/randomised bench for ps2_host_tx with a behavioural PS/2 device on an
// open-drain bus and a frame model built from the byte, parity and framing rules.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int err_stray = 0;

    logic [10:0] exp_q[$];
    logic        done_q[$];

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk  = ps2_clk_oe  ? 1'b0 : dev_clk;
    assign ps2_data = ps2_data_oe ? 1'b0 : dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .data_in     (data_in),
        .valid       (valid),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_q.push_back(err);
        if (clrn && err && !done) err_stray++;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line sequence the device should see: start, b0..b7, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i + 1] = b[i];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic offer(input logic [7:0] b, input bit hold, input logic [7:0] nb);
        @(negedge clk);
        data_in = b;
        valid   = 1'b1;
        @(negedge clk);
        if (hold) data_in = nb;
        else valid = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_rts();
        int n;
        n = 0;
        while (!ps2_clk_oe && n < INH + 20) begin @(negedge clk); n++; end
        n = 0;
        while (ps2_clk_oe && n < INH + 20) begin @(negedge clk); n++; end
        check("rts_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
        check("rts_start_driven", {31'd0, ps2_data_oe}, 32'd1);
    endtask

    task automatic device(input int n_edges, input bit ack, output logic [10:0] seen);
        int h;
        seen = '1;
        h = $urandom_range(4, 12);
        for (int i = 0; i < n_edges; i++) begin
            repeat (h / 2) @(negedge clk);
            seen[i] = ps2_data;
            if (i == 10 && ack) dev_data = 1'b0;
            repeat (h - h / 2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (h) @(negedge clk);
            dev_clk = 1'b1;
        end
        repeat (h) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < 400) begin @(negedge clk); #1; n++; end
        check({tag, "_done_seen"}, {31'd0, done_q.size() > 0}, 32'd1);
        if (done_q.size() > 0) check({tag, "_err"}, {31'd0, done_q.pop_front()}, {31'd0, exp_err});
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_single_done"}, done_q.size(), 32'd0);
    endtask

    task automatic transfer(input string tag, input logic [7:0] b, input bit ack);
        logic [10:0] seen;
        offer(b, 1'b0, 8'h00);
        exp_q.push_back(frame_of(b));
        wait_rts();
        device(11, ack, seen);
        check({tag, "_frame"}, {21'd0, seen}, {21'd0, exp_q.pop_front()});
        wait_done(tag, !ack);
    endtask

    initial begin
        logic [10:0] seen;
        logic [7:0]  a;
        logic [7:0]  b;
        int          inh;
        int          snd;
        bit          found;

        // Reset state
        #17;
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Directed bytes: ACKed 0xED, parity-one 0x00, NACKed byte
        transfer("ed_ack", 8'hED, 1'b1);
        transfer("zero_ack", 8'h00, 1'b1);
        transfer("nack", 8'h3C, 1'b0);

        // Silent device: inhibit length, then watchdog expiry
        offer(8'hA5, 1'b0, 8'h00);
        inh = 0;
        snd = 0;
        found = 0;
        for (int i = 0; i < INH + TMO + 50; i++) begin
            if (done) begin found = 1; break; end
            if (ps2_clk_oe) inh++;
            else if (ps2_data_oe) snd++;
            @(negedge clk);
        end
        check("tmo_found", {31'd0, found}, 32'd1);
        check("tmo_inhibit_len", inh, INH);
        check("tmo_send_len", snd, TMO);
        check("tmo_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        wait_done("tmo", 1'b1);

        // Reset in the middle of a frame
        offer(8'h00, 1'b0, 8'h00);
        wait_rts();
        device(5, 1'b1, seen);
        check("abort_partial_frame", {27'd0, seen[4:0]}, {27'd0, 5'b00000});
        check("abort_data_low", {31'd0, ps2_data_oe}, 32'd1);
        #2;
        clrn = 1'b0;
        #1;
        check("abort_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        done_q.delete();
        repeat (40) @(negedge clk);
        check("abort_no_done", done_q.size(), 32'd0);
        transfer("after_abort_f4", 8'hF4, 1'b1);

        // valid held with changing data_in during a frame
        a = 8'($urandom_range(0, 255));
        b = a ^ 8'h5A;
        offer(a, 1'b1, b);
        exp_q.push_back(frame_of(a));
        check("hold_ready_inhibit", {31'd0, ready}, 32'd0);
        wait_rts();
        check("hold_ready_send", {31'd0, ready}, 32'd0);
        device(11, 1'b1, seen);
        check("hold_first_frame", {21'd0, seen}, {21'd0, exp_q.pop_front()});
        wait_done("hold_first", 1'b0);
        check("hold_second_accepted", {31'd0, busy}, 32'd1);
        valid = 1'b0;
        exp_q.push_back(frame_of(b));
        wait_rts();
        device(11, 1'b1, seen);
        check("hold_second_frame", {21'd0, seen}, {21'd0, exp_q.pop_front()});
        wait_done("hold_second", 1'b0);

        // Random bytes with random ACK/NACK
        for (int k = 0; k < 6; k++) begin
            transfer("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        check("err_only_with_done", err_stray, 32'd0);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
